multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I datapath. It steps each instruction through IF/ID/EX/MEM/WB states and arbitrates the single shared memory port between instruction fetch and load/store access. It drives PC/IR/register-file write strobes, memory request handshakes, a retired-instruction counter, and illegal-opcode / bus-timeout traps. Its inputs are the IR opcode field, the branch comparator result and the memory ready signal.

---
 rtl/multicycle_ctrl_if.sv | 22 ++
 rtl/multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Shared memory-port handshake between the multicycle sequencer and the memory.
// The sequencer drives the request side; the memory answers with mem_ready.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle sequencer: steps IF/ID/EX/MEM/WB, arbitrates the single memory
// port, counts retired instructions and traps on illegal opcodes or bus timeouts.
module multicycle_ctrl #(
    parameter int CNT_W      = 32,
    parameter int WAIT_LIMIT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [6:0]        op,
    input  logic              branch_taken,
    multicycle_ctrl_if.master mem,
    output logic              ir_wr,
    output logic              mdr_wr,
    output logic              reg_wr,
    output logic              pc_wr,
    output logic              pc_src,
    output logic              retire,
    output logic [CNT_W-1:0]  instret,
    output logic [2:0]        state,
    output logic              illegal,
    output logic              bus_err
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_TRAP = 3'd7;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;

    localparam int NUM_OPS = 9;
    localparam logic [6:0] VALID_OPS [NUM_OPS] = '{
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
        OP_LOAD, OP_STORE, OP_ALUI, OP_ALU
    };

    // Counter only needs to reach WAIT_LIMIT; with the timeout disabled it is a dummy bit.
    localparam int WAIT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [31:0]       LIMIT_U    = 32'(WAIT_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  INSTRET_ONE = CNT_W'(1);

    logic [2:0]        state_reg, state_next;
    logic [CNT_W-1:0]  instret_reg;
    logic              illegal_reg, bus_err_reg;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              req_hold_reg, req_hold_next;

    logic [NUM_OPS-1:0] op_hit;
    logic               op_legal;
    logic               is_store;
    logic               is_jump;
    logic               wait_hit;
    logic [31:0]        wait_ext;
    logic               req_active, we_active, data_sel;
    logic               set_illegal, set_bus_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_op_dec
            assign op_hit[gi] = (op == VALID_OPS[gi]);
        end
    endgenerate

    assign op_legal = |op_hit;
    assign is_store = (op == OP_STORE);
    assign is_jump  = (op == OP_JAL) || (op == OP_JALR);
    assign wait_ext = 32'(wait_cnt_reg);
    // True when one more non-ready request cycle would reach the limit.
    assign wait_hit = (WAIT_LIMIT != 0) && ((wait_ext + 32'd1) == LIMIT_U);

    always_comb begin
        state_next  = state_reg;
        req_active  = 1'b0;
        we_active   = 1'b0;
        data_sel    = 1'b0;
        ir_wr       = 1'b0;
        mdr_wr      = 1'b0;
        reg_wr      = 1'b0;
        pc_wr       = 1'b0;
        pc_src      = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        case (state_reg)
            S_IF: begin
                // A raised fetch stays up until accepted, even if run drops.
                req_active = run | req_hold_reg;
                if (req_active) begin
                    if (mem.mem_ready) begin
                        ir_wr      = 1'b1;
                        state_next = S_ID;
                    end else if (wait_hit) begin
                        set_bus_err = 1'b1;
                        state_next  = S_TRAP;
                    end
                end
            end
            S_ID: begin
                if (op_legal) begin
                    state_next = S_EX;
                end else begin
                    set_illegal = 1'b1;
                    state_next  = S_TRAP;
                end
            end
            S_EX: begin
                if (op == OP_BRANCH) begin
                    pc_wr      = 1'b1;
                    pc_src     = branch_taken;
                    retire     = 1'b1;
                    state_next = S_IF;
                end else if ((op == OP_LOAD) || is_store) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                req_active = 1'b1;
                data_sel   = 1'b1;
                we_active  = is_store;
                if (mem.mem_ready) begin
                    if (is_store) begin
                        pc_wr      = 1'b1;
                        retire     = 1'b1;
                        state_next = S_IF;
                    end else begin
                        mdr_wr     = 1'b1;
                        state_next = S_WB;
                    end
                end else if (wait_hit) begin
                    set_bus_err = 1'b1;
                    state_next  = S_TRAP;
                end
            end
            S_WB: begin
                reg_wr     = 1'b1;
                pc_wr      = 1'b1;
                pc_src     = is_jump;
                retire     = 1'b1;
                state_next = S_IF;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_TRAP;
            end
        endcase
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if ((state_next != state_reg) || mem.mem_ready) begin
            wait_cnt_next = '0;
        end else if (req_active) begin
            wait_cnt_next = wait_cnt_reg + WAIT_ONE;
        end
    end

    assign req_hold_next = (state_reg == S_IF) && req_active && !mem.mem_ready
                           && (state_next == S_IF);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IF;
            instret_reg  <= '0;
            illegal_reg  <= 1'b0;
            bus_err_reg  <= 1'b0;
            wait_cnt_reg <= '0;
            req_hold_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            req_hold_reg <= req_hold_next;
            if (retire) begin
                instret_reg <= instret_reg + INSTRET_ONE;
            end
            if (set_illegal) begin
                illegal_reg <= 1'b1;
            end
            if (set_bus_err) begin
                bus_err_reg <= 1'b1;
            end
        end
    end

    assign mem.mem_req  = req_active;
    assign mem.mem_we   = we_active;
    assign mem.addr_sel = data_sel;
    assign instret      = instret_reg;
    assign state        = state_reg;
    assign illegal      = illegal_reg;
    assign bus_err      = bus_err_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into a per-cycle phase plan
// from its class and memory wait counts, then compared against the DUT cycle by cycle.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;
    localparam int WL    = 4;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011,
                           ST = 7'b0100011, ALUI = 7'b0010011, ALU = 7'b0110011;

    typedef enum int {P_IF, P_ID, P_EX, P_MEM, P_WB, P_TRAP} ph_t;
    typedef struct {
        ph_t  ph;
        logic rdy;
    } step_t;

    logic             clk = 1'b0;
    logic             rst_n, run, branch_taken;
    logic [6:0]       op;
    logic             ir_wr, mdr_wr, reg_wr, pc_wr, pc_src, retire;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state;
    logic             illegal, bus_err;

    multicycle_ctrl_if mif();

    multicycle_ctrl #(.CNT_W(CNT_W), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .op(op), .branch_taken(branch_taken),
        .mem(mif), .ir_wr(ir_wr), .mdr_wr(mdr_wr), .reg_wr(reg_wr), .pc_wr(pc_wr),
        .pc_src(pc_src), .retire(retire), .instret(instret), .state(state),
        .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   exp_instret = 0;
    logic exp_ill  = 1'b0;
    logic exp_berr = 1'b0;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] obs_vec();
        return {state, mif.mem_req, mif.mem_we, mif.addr_sel,
                ir_wr, mdr_wr, reg_wr, pc_wr, pc_src, retire};
    endfunction

    function automatic logic is_legal(input logic [6:0] o);
        return (o == LUI) || (o == AUIPC) || (o == JAL) || (o == JALR) || (o == BR) ||
               (o == LD) || (o == ST) || (o == ALUI) || (o == ALU);
    endfunction

    // Strobes each phase must show, straight from the phase descriptions.
    function automatic logic [11:0] expect_vec(input ph_t ph, input logic [6:0] o,
                                               input logic b, input logic rdy);
        logic [2:0] st;
        logic rq, we, as, irw, mdw, rw, pw, ps, rt;
        st = 3'd0; rq = 0; we = 0; as = 0; irw = 0; mdw = 0; rw = 0; pw = 0; ps = 0; rt = 0;
        case (ph)
            P_IF:  begin st = 3'd0; rq = 1; irw = rdy; end
            P_ID:  st = 3'd1;
            P_EX:  begin
                st = 3'd2;
                if (o == BR) begin pw = 1; ps = b; rt = 1; end
            end
            P_MEM: begin
                st = 3'd3; rq = 1; as = 1; we = (o == ST);
                if (rdy) begin
                    if (o == ST) begin pw = 1; rt = 1; end
                    else mdw = 1;
                end
            end
            P_WB:  begin
                st = 3'd4; rw = 1; pw = 1; rt = 1; ps = (o == JAL) || (o == JALR);
            end
            default: st = 3'd7;
        endcase
        return {st, rq, we, as, irw, mdw, rw, pw, ps, rt};
    endfunction

    task automatic drive(input logic r, input logic [6:0] o, input logic b,
                         input logic rdy, input logic rn);
        @(negedge clk);
        rst_n = rn; run = r; op = o; branch_taken = b; mif.mem_ready = rdy;
        #1;
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_instret"}, 32'(instret), 32'(exp_instret));
        chk({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
        chk({tag, "_bus_err"}, 32'(bus_err), 32'(exp_berr));
    endtask

    task automatic do_reset();
        drive(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 7'd0, 1'b0, 1'b1, 1'b1);
        exp_instret = 0; exp_ill = 1'b0; exp_berr = 1'b0;
        chk("reset_vec", 32'(obs_vec()), 32'd0);
        check_flags("reset");
    endtask

    task automatic trap_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, op, 1'b0, 1'($urandom), 1'b1);
            chk("trap_vec", 32'(obs_vec()), 32'(expect_vec(P_TRAP, op, 1'b0, 1'b0)));
        end
    endtask

    // Expand one memory access of w non-ready cycles; returns 1 if it times out.
    function automatic logic add_access(ref step_t plan[$], input ph_t ph, input int w);
        step_t s;
        int n;
        n = ((WL != 0) && (w >= WL)) ? WL : w;
        for (int i = 0; i < n; i++) begin
            s.ph = ph; s.rdy = 1'b0; plan.push_back(s);
        end
        if ((WL != 0) && (w >= WL)) return 1'b1;
        s.ph = ph; s.rdy = 1'b1; plan.push_back(s);
        return 1'b0;
    endfunction

    task automatic run_instr(input logic [6:0] o, input logic b, input int wif,
                             input int wmem, output logic trapped);
        step_t plan[$];
        step_t s;
        trapped = add_access(plan, P_IF, wif);
        if (trapped) exp_berr = 1'b1;
        if (!trapped) begin
            s.ph = P_ID; s.rdy = 1'($urandom); plan.push_back(s);
            if (!is_legal(o)) begin
                trapped = 1'b1; exp_ill = 1'b1;
            end else begin
                s.ph = P_EX; s.rdy = 1'($urandom); plan.push_back(s);
                if ((o == LD) || (o == ST)) begin
                    trapped = add_access(plan, P_MEM, wmem);
                    if (trapped) exp_berr = 1'b1;
                    else if (o == LD) begin
                        s.ph = P_WB; s.rdy = 1'($urandom); plan.push_back(s);
                    end
                end else if (o != BR) begin
                    s.ph = P_WB; s.rdy = 1'($urandom); plan.push_back(s);
                end
            end
        end
        if (!trapped) exp_instret = (exp_instret + 1) % (1 << CNT_W);
        foreach (plan[i]) begin
            drive(1'b1, o, b, plan[i].rdy, 1'b1);
            chk($sformatf("op%b_c%0d", o, i), 32'(obs_vec()),
                32'(expect_vec(plan[i].ph, o, b, plan[i].rdy)));
        end
        @(posedge clk);
        #1;
        check_flags($sformatf("op%b_end", o));
        if (trapped) chk("trap_state", 32'(state), 32'd7);
        $display("instr op=%b bt=%0d wif=%0d wmem=%0d cycles=%0d trapped=%0d instret=%0d",
                 o, b, wif, wmem, plan.size(), trapped, instret);
    endtask

    logic [6:0] ops [9] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, ALUI, ALU};

    initial begin
        logic tr;
        logic [6:0] ro;
        int wi, wm;
        rst_n = 1'b0; run = 1'b0; op = 7'd0; branch_taken = 1'b0; mif.mem_ready = 1'b0;
        do_reset();

        // Idle with run low: no request, stay in IF
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, ALU, 1'b0, 1'($urandom), 1'b1);
            chk("idle_vec", 32'(obs_vec()), 32'd0);
        end

        // Fetch raised then run dropped: request must persist until ready
        drive(1'b1, ALU, 1'b0, 1'b0, 1'b1);
        chk("hold_c0", 32'(obs_vec()), 32'(expect_vec(P_IF, ALU, 1'b0, 1'b0)));
        drive(1'b0, ALU, 1'b0, 1'b0, 1'b1);
        chk("hold_c1", 32'(obs_vec()), 32'(expect_vec(P_IF, ALU, 1'b0, 1'b0)));
        drive(1'b0, ALU, 1'b0, 1'b1, 1'b1);
        chk("hold_c2", 32'(obs_vec()), 32'(expect_vec(P_IF, ALU, 1'b0, 1'b1)));
        drive(1'b0, ALU, 1'b0, 1'b0, 1'b1);
        chk("hold_id", 32'(obs_vec()), 32'(expect_vec(P_ID, ALU, 1'b0, 1'b0)));
        drive(1'b0, ALU, 1'b0, 1'b0, 1'b1);
        chk("hold_ex", 32'(obs_vec()), 32'(expect_vec(P_EX, ALU, 1'b0, 1'b0)));
        drive(1'b0, ALU, 1'b0, 1'b0, 1'b1);
        chk("hold_wb", 32'(obs_vec()), 32'(expect_vec(P_WB, ALU, 1'b0, 1'b0)));
        exp_instret = 1;
        drive(1'b0, ALU, 1'b0, 1'b1, 1'b1);
        chk("hold_idle", 32'(obs_vec()), 32'd0);
        check_flags("hold");

        // Directed instruction classes
        run_instr(ALU, 1'b0, 0, 0, tr);
        run_instr(LD, 1'b0, 0, 3, tr);
        run_instr(BR, 1'b1, 0, 0, tr);
        run_instr(BR, 1'b0, 0, 0, tr);
        run_instr(ST, 1'b0, 1, 2, tr);
        run_instr(JAL, 1'b0, 0, 0, tr);
        run_instr(JALR, 1'b1, 2, 0, tr);
        run_instr(LUI, 1'b0, 0, 0, tr);
        run_instr(AUIPC, 1'b0, 0, 0, tr);
        run_instr(ALUI, 1'b0, 3, 0, tr);

        // Illegal opcode trap, sticky until reset
        run_instr(7'b0000000, 1'b0, 0, 0, tr);
        trap_cycles(20);
        do_reset();

        // Fetch timeout, then ready on the last allowed cycle
        run_instr(ALU, 1'b0, 10, 0, tr);
        trap_cycles(3);
        do_reset();
        run_instr(ALU, 1'b0, WL - 1, 0, tr);
        run_instr(LD, 1'b0, 0, 7, tr);
        trap_cycles(2);
        do_reset();
        run_instr(ALU, 1'b0, 0, 0, tr);

        // Reset while a store waits in MEM
        drive(1'b1, ST, 1'b0, 1'b1, 1'b1);
        drive(1'b1, ST, 1'b0, 1'b0, 1'b1);
        drive(1'b1, ST, 1'b0, 1'b0, 1'b1);
        drive(1'b1, ST, 1'b0, 1'b0, 1'b1);
        chk("st_wait", 32'(obs_vec()), 32'(expect_vec(P_MEM, ST, 1'b0, 1'b0)));
        drive(1'b1, ST, 1'b0, 1'b0, 1'b0);
        drive(1'b0, ST, 1'b0, 1'b0, 1'b1);
        exp_instret = 0;
        chk("st_rst_vec", 32'(obs_vec()), 32'd0);
        check_flags("st_rst");

        // Counter wrap at 2^CNT_W
        for (int i = 0; i < (1 << CNT_W) - 1; i++) run_instr(BR, 1'($urandom), 0, 0, tr);
        chk("wrap_max", 32'(instret), 32'((1 << CNT_W) - 1));
        run_instr(BR, 1'b1, 0, 0, tr);
        chk("wrap_zero", 32'(instret), 32'd0);

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                ro = 7'($urandom);
                while (is_legal(ro)) ro = 7'($urandom);
            end else begin
                ro = ops[$urandom_range(0, 8)];
            end
            wi = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 6));
            wm = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 6));
            run_instr(ro, 1'($urandom), wi, wm, tr);
            if (tr) begin
                trap_cycles(2);
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
